spart: RTL and testbench
========================

SPART -- requirements
Module: spart

Interface
REQ-001 SHALL have parameter: RESET_DIV, 16'd651, baud divisor loaded at reset (16x oversample tick period in clk cycles).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: iocs  input  1  bus chip select.
REQ-005 SHALL have port: iorw  input  1  1 = read by host, 0 = write by host.
REQ-006 SHALL have port: ioaddr  input  2  register select: 00 RX/TX buffer, 01 status, 10 DB low, 11 DB high.
REQ-007 SHALL have port: databus  inout  8  shared bidirectional data bus.
REQ-008 SHALL have port: rda  output  1  receive data available.
REQ-009 SHALL have port: tbr  output  1  transmit buffer ready.
REQ-010 SHALL have port: txd  output  1  serial out, idle high.
REQ-011 SHALL have port: rxd  input  1  serial in, asynchronous, idle high.

Function
REQ-012 SHALL drive databus only when iocs=1, iorw=1 and ioaddr=00 (or 01 with SPART_STATUS_EN), else high-Z; read data combinational in the same cycle.
REQ-013 SHALL load DB[7:0] on iocs=1, iorw=0, ioaddr=10; DB[15:8] on ioaddr=11; baud counter reloads with the updated divisor the next cycle.
REQ-014 Baud generator SHALL be a down-counter emitting one-cycle tick every DB cycles; DB=0 treated as DB=1.
REQ-015 TX write (iocs=1, iorw=0, ioaddr=00) SHALL be accepted only when tbr=1; tbr falls the following cycle; writes while tbr=0 are ignored.
REQ-016 TX FSM states IDLE -> SHIFT -> IDLE; frame = start 0, 8 data LSB first, stop 1; each bit held exactly 16 ticks.
REQ-017 tbr SHALL rise in the cycle after the 16th tick of the stop bit; back-to-back write that cycle starts next frame with no idle bit.
REQ-018 rxd SHALL pass a 2-flop synchronizer before any use.
REQ-019 RX FSM states IDLE, START, DATA, STOP; IDLE -> START on synchronized falling edge; tick counter zeroed on entry.
REQ-020 START: rxd sampled at tick 8; if 1 (false start) return to IDLE, no rda change.
REQ-021 DATA: each bit sampled at tick 8 of its bit period (16 ticks after previous sample), LSB first, 8 bits.
REQ-022 STOP: sampled at tick 8; if 1, rx_buf updated and rda set next cycle; if 0, byte discarded, framing-error flag set, rda unchanged; return to IDLE.
REQ-023 Host read of ioaddr=00 SHALL clear rda the following cycle.
REQ-024 Overrun: new byte completing while rda=1 SHALL overwrite rx_buf, rda stays 1.
REQ-025 Simultaneous host read and byte completion: new byte wins, rda stays 1.
REQ-026 RX and TX SHALL operate fully independently (full duplex).

Reset
REQ-027 On rst_n=0 at a clock edge: txd=1, tbr=1, rda=0, rx_buf=0, DB=RESET_DIV, both FSMs IDLE, counters 0, framing flag 0.
REQ-028 Reset mid-frame SHALL abort both frames; txd high from the next edge; no partial byte delivered.

Configuration
REQ-029 Macro SPART_STATUS_EN defined: read of ioaddr=01 returns {5'b0, ferr, tbr, rda}; that read clears ferr next cycle.
REQ-030 SPART_STATUS_EN undefined: ioaddr=01 is neither driven nor decoded, databus stays high-Z; ferr not implemented.

Verification
REQ-031 Reset, no bus activity -> txd=1, tbr=1, rda=0, databus Z for 100 cycles.
REQ-032 DB=4 (write 10<=04, 11<=00), TX write 8'hA5 -> txd 0,1,0,1,0,0,1,0,1,1 each 64 cycles; tbr 0 for 640 cycles then 1.
REQ-033 DB=4, rxd frame for 8'h3C at 64 cycles/bit -> rda=1 after stop sample; read ioaddr=00 returns 8'h3C, rda=0 next cycle.
REQ-034 DB=4, rxd low for 20 cycles then high -> false start, rda stays 0; following valid 8'h81 received correctly.
REQ-035 DB=4, frame 8'h55 with stop bit 0 -> rda stays 0; with SPART_STATUS_EN status read returns 8'h04.
REQ-036 Two frames 8'h11 then 8'h22 without host read -> rda=1, read returns 8'h22; assert rst_n mid-TX-frame -> txd=1 next edge, tbr=1.

Source files
------------

// File: rtl/spart_if.sv
// Host register bus and serial lines of the SPART.
// The slave modport is the UART side; the master modport is the host/bench side.
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;

    modport slave  (input  iocs, iorw, ioaddr, rxd, output rda, tbr, txd);
    modport master (output iocs, iorw, ioaddr, rxd, input  rda, tbr, txd);
endinterface

// File: rtl/spart.sv
// SPART: 8N1 UART with a 16x-oversampling programmable baud generator and a host register bus.
// Defining SPART_STATUS_EN adds the status register at ioaddr 01 and the framing-error flag.
module spart #(
    parameter logic [15:0] RESET_DIV = 16'd651
) (
    input  logic       clk,
    input  logic       rst_n,
    spart_if.slave     bus,
    inout  wire  [7:0] databus
);

    typedef enum logic { TX_IDLE = 1'b0, TX_SHIFT = 1'b1 } tx_state_e;
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    logic        wr_s, rd_s, tx_wr_s, db_lo_wr_s, db_hi_wr_s, rx_rd_s;
    logic        rd_oe_s;
    logic [7:0]  rd_data_s;

    logic [15:0] db_q, db_d, baud_cnt_q, baud_cnt_d, div_m1_s;
    logic        db_wr_q, db_wr_d, tick_s;

    tx_state_e   tx_state_q, tx_state_d;
    logic [3:0]  tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
    logic [8:0]  tx_frame_q, tx_frame_d;
    logic        txd_q, txd_d, tbr_q, tbr_d;

    logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_fall_s;
    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  rx_tick_q, rx_tick_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
    logic        rda_q, rda_d, rx_done_s;
`ifdef SPART_STATUS_EN
    logic        st_rd_s, ferr_q, ferr_d, ferr_set_s;
`endif

    assign wr_s       = bus.iocs & ~bus.iorw;
    assign rd_s       = bus.iocs &  bus.iorw;
    assign tx_wr_s    = wr_s & (bus.ioaddr == 2'b00) & tbr_q;
    assign db_lo_wr_s = wr_s & (bus.ioaddr == 2'b10);
    assign db_hi_wr_s = wr_s & (bus.ioaddr == 2'b11);
    assign rx_rd_s    = rd_s & (bus.ioaddr == 2'b00);
`ifdef SPART_STATUS_EN
    assign st_rd_s    = rd_s & (bus.ioaddr == 2'b01);
`endif

    assign bus.rda = rda_q;
    assign bus.tbr = tbr_q;
    assign bus.txd = txd_q;

    // Read-data mux; the bus is driven combinationally only while a decoded read is active.
    always_comb begin
        rd_oe_s   = 1'b0;
        rd_data_s = 8'h00;
        if (rx_rd_s) begin
            rd_oe_s   = 1'b1;
            rd_data_s = rx_buf_q;
        end
`ifdef SPART_STATUS_EN
        else if (st_rd_s) begin
            rd_oe_s   = 1'b1;
            rd_data_s = {5'b00000, ferr_q, tbr_q, rda_q};
        end
`endif
        else begin
            rd_oe_s   = 1'b0;
        end
    end

    assign databus   = rd_oe_s ? rd_data_s : 8'hzz;
    assign div_m1_s  = (db_q == 16'd0) ? 16'd0 : (db_q - 16'd1);
    assign rx_fall_s = rx_prev_q & ~rx_sync_q;

    // Divisor register and baud down-counter; a divisor write restarts the count one cycle later.
    always_comb begin
        db_d       = db_q;
        db_wr_d    = db_lo_wr_s | db_hi_wr_s;
        tick_s     = 1'b0;
        baud_cnt_d = baud_cnt_q;
        if (db_lo_wr_s) begin
            db_d[7:0]  = databus;
        end else if (db_hi_wr_s) begin
            db_d[15:8] = databus;
        end else begin
            db_d       = db_q;
        end
        if (db_wr_q) begin
            baud_cnt_d = div_m1_s;
        end else if (baud_cnt_q == 16'd0) begin
            tick_s     = 1'b1;
            baud_cnt_d = div_m1_s;
        end else begin
            baud_cnt_d = baud_cnt_q - 16'd1;
        end
    end

    // Transmitter: bit 0 is the start bit, bit 9 the stop bit; the stop bit is already on txd.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        txd_d      = txd_q;
        tbr_d      = tbr_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_wr_s) begin
                    tx_state_d = TX_SHIFT;
                    tx_frame_d = {1'b1, databus};
                    tx_tick_d  = 4'd0;
                    tx_bit_d   = 4'd0;
                    txd_d      = 1'b0;
                    tbr_d      = 1'b0;
                end else begin
                    txd_d      = 1'b1;
                    tbr_d      = 1'b1;
                end
            end
            TX_SHIFT: begin
                if (tick_s) begin
                    if (tx_tick_q == 4'd15) begin
                        tx_tick_d = 4'd0;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_d = TX_IDLE;
                            txd_d      = 1'b1;
                            tbr_d      = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 4'd1;
                            txd_d      = tx_frame_q[0];
                            tx_frame_d = {1'b1, tx_frame_q[8:1]};
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end else begin
                    tx_tick_d = tx_tick_q;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
                tbr_d      = 1'b1;
            end
        endcase
    end

    // Receiver: start bit checked at its 8th tick, every later sample 16 ticks after the previous one.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_s  = 1'b0;
`ifdef SPART_STATUS_EN
        ferr_set_s = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall_s) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = 4'd0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick_s && (rx_tick_q == 4'd7)) begin
                    rx_tick_d  = 4'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else if (tick_s) begin
                    rx_tick_d  = rx_tick_q + 4'd1;
                end else begin
                    rx_tick_d  = rx_tick_q;
                end
            end
            RX_DATA: begin
                if (tick_s && (rx_tick_q == 4'd15)) begin
                    rx_tick_d  = 4'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d   = rx_bit_q + 3'd1;
                    end
                end else if (tick_s) begin
                    rx_tick_d  = rx_tick_q + 4'd1;
                end else begin
                    rx_tick_d  = rx_tick_q;
                end
            end
            RX_STOP: begin
                if (tick_s && (rx_tick_q == 4'd15)) begin
                    rx_tick_d  = 4'd0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_done_s  = 1'b1;
                    end
`ifdef SPART_STATUS_EN
                    else begin
                        ferr_set_s = 1'b1;
                    end
`else
                    else begin
                        rx_done_s  = 1'b0;
                    end
`endif
                end else if (tick_s) begin
                    rx_tick_d  = rx_tick_q + 4'd1;
                end else begin
                    rx_tick_d  = rx_tick_q;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_tick_d  = 4'd0;
            end
        endcase
    end

    // A completing byte takes priority over a host read clearing rda.
    always_comb begin
        rx_buf_d = rx_done_s ? rx_shift_q : rx_buf_q;
        if (rx_done_s) begin
            rda_d = 1'b1;
        end else if (rx_rd_s) begin
            rda_d = 1'b0;
        end else begin
            rda_d = rda_q;
        end
`ifdef SPART_STATUS_EN
        if (ferr_set_s) begin
            ferr_d = 1'b1;
        end else if (st_rd_s) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
`endif
    end

    // State registers with synchronous active-low reset; rxd synchronizer resets to idle-high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q       <= RESET_DIV;
            db_wr_q    <= 1'b0;
            baud_cnt_q <= 16'd0;
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 4'd0;
            tx_frame_q <= 9'h1FF;
            txd_q      <= 1'b1;
            tbr_q      <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
`ifdef SPART_STATUS_EN
            ferr_q     <= 1'b0;
`endif
        end else begin
            db_q       <= db_d;
            db_wr_q    <= db_wr_d;
            baud_cnt_q <= baud_cnt_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
            txd_q      <= txd_d;
            tbr_q      <= tbr_d;
            rx_meta_q  <= bus.rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
`ifdef SPART_STATUS_EN
            ferr_q     <= ferr_d;
`endif
        end
    end

endmodule

// File: tb/tb_spart.sv
// Directed self-checking bench for spart: reset, baud setup, TX frame timing, RX paths, status, reset abort.
module tb_spart;

    logic       clk = 1'b0;
    logic       rst_n;
    wire  [7:0] databus;
    logic [7:0] drv_data;
    logic       drv_en;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         tick_ref = 0;
    logic [7:0] rd_val;
    logic [9:0] fr;
    logic [7:0] st_exp1;
    logic [7:0] st_exp2;

    spart_if bus_if ();

    spart #(.RESET_DIV(16'd651)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .databus (databus)
    );

    assign databus = drv_en ? drv_data : 8'hzz;

    // Undriven bus reads back as all ones, so a stray DUT drive is visible.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (databus[g]);
    end

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_if.iocs   = 1'b1;
        bus_if.iorw   = 1'b0;
        bus_if.ioaddr = a;
        drv_data      = d;
        drv_en        = 1'b1;
        step();
        bus_if.iocs   = 1'b0;
        drv_en        = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_if.iocs   = 1'b1;
        bus_if.iorw   = 1'b1;
        bus_if.ioaddr = a;
        #1;
        d = databus;
        step();
        bus_if.iocs   = 1'b0;
        bus_if.iorw   = 1'b0;
        bus_if.ioaddr = 2'b00;
    endtask

    // One 8N1 frame at 64 cycles per bit; optionally starts a TX write at the start of the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic mid_rda,
                              input logic tx_en, input logic [7:0] tx_data);
        bus_if.rxd = 1'b0;
        repeat (64) step();
        for (int i = 0; i < 8; i++) begin
            bus_if.rxd = d[i];
            repeat (64) step();
        end
        bus_if.rxd = stop_bit;
        chk1("rda_before_stop", bus_if.rda, mid_rda);
        if (tx_en) begin
            bus_write(2'b00, tx_data);
            repeat (63) step();
        end else begin
            repeat (64) step();
        end
        bus_if.rxd = 1'b1;
    endtask

    initial begin
`ifdef SPART_STATUS_EN
        st_exp1 = 8'h04;
        st_exp2 = 8'h00;
`else
        st_exp1 = 8'hFF;
        st_exp2 = 8'hFF;
`endif
        rst_n         = 1'b0;
        bus_if.iocs   = 1'b0;
        bus_if.iorw   = 1'b0;
        bus_if.ioaddr = 2'b00;
        bus_if.rxd    = 1'b1;
        drv_data      = 8'h00;
        drv_en        = 1'b0;
        step();
        step();
        chk1("reset_txd", bus_if.txd, 1'b1);
        chk1("reset_tbr", bus_if.tbr, 1'b1);
        chk1("reset_rda", bus_if.rda, 1'b0);
        rst_n = 1'b1;

        // Idle for 100 cycles with no bus activity.
        for (int i = 0; i < 100; i++) begin
            step();
            chk1("idle_txd", bus_if.txd, 1'b1);
            chk1("idle_tbr", bus_if.tbr, 1'b1);
            chk1("idle_rda", bus_if.rda, 1'b0);
            chk8("idle_databus", databus, 8'hFF);
        end

        bus_read(2'b01, rd_val);
        chk8("status_idle", rd_val, (st_exp1 == 8'hFF) ? 8'hFF : 8'h02);

        // DB = 4; ticks then fall in cycles tick_ref + 4k.
        tick_ref = cyc + 6;
        bus_write(2'b10, 8'h04);
        bus_write(2'b11, 8'h00);
        while ((cyc < tick_ref) || (((cyc - tick_ref) % 4) != 0)) step();

        // TX 8'hA5 issued in a tick cycle: every bit is exactly 64 cycles.
        fr = {1'b1, 8'hA5, 1'b0};
        bus_write(2'b00, 8'hA5);
        for (int b = 0; b < 10; b++) begin
            chk1("tx_bit_first", bus_if.txd, fr[b]);
            chk1("tx_tbr_low", bus_if.tbr, 1'b0);
            repeat (63) step();
            chk1("tx_bit_last", bus_if.txd, fr[b]);
            chk1("tx_tbr_low_end", bus_if.tbr, 1'b0);
            step();
        end
        chk1("tx_tbr_back", bus_if.tbr, 1'b1);
        chk1("tx_txd_idle", bus_if.txd, 1'b1);
        bus_write(2'b00, 8'hFF);
        chk1("tx_second_start", bus_if.txd, 1'b0);
        repeat (700) step();
        chk1("tx_second_done", bus_if.tbr, 1'b1);

        // RX 8'h3C, then read clears rda.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk1("rx3c_rda", bus_if.rda, 1'b1);
        bus_read(2'b00, rd_val);
        chk8("rx3c_data", rd_val, 8'h3C);
        chk1("rx3c_rda_clr", bus_if.rda, 1'b0);

        // False start of 20 cycles, then a valid 8'h81.
        bus_if.rxd = 1'b0;
        repeat (20) step();
        bus_if.rxd = 1'b1;
        repeat (60) step();
        chk1("false_start_rda", bus_if.rda, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk1("rx81_rda", bus_if.rda, 1'b1);
        bus_read(2'b00, rd_val);
        chk8("rx81_data", rd_val, 8'h81);
        chk1("rx81_rda_clr", bus_if.rda, 1'b0);

        // Framing error on 8'h55 while a TX frame runs concurrently.
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8'h5A);
        step();
        step();
        chk1("ferr_rda", bus_if.rda, 1'b0);
        chk1("ferr_tbr_busy", bus_if.tbr, 1'b0);
        bus_read(2'b01, rd_val);
        chk8("status_ferr", rd_val, st_exp1);
        bus_read(2'b01, rd_val);
        chk8("status_ferr_clr", rd_val, st_exp2);
        bus_read(2'b00, rd_val);
        chk8("ferr_buf_kept", rd_val, 8'h81);
        repeat (700) step();
        chk1("duplex_tx_done", bus_if.tbr, 1'b1);
        chk1("duplex_txd_idle", bus_if.txd, 1'b1);

        // Overrun: second byte overwrites the first.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 8'h00);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        step();
        chk1("overrun_rda", bus_if.rda, 1'b1);
        bus_read(2'b00, rd_val);
        chk8("overrun_data", rd_val, 8'h22);
        chk1("overrun_rda_clr", bus_if.rda, 1'b0);

        // Reset in the middle of a TX frame with a byte pending in the RX buffer.
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk1("pre_reset_rda", bus_if.rda, 1'b1);
        bus_write(2'b00, 8'h00);
        repeat (200) step();
        chk1("pre_reset_txd", bus_if.txd, 1'b0);
        chk1("pre_reset_tbr", bus_if.tbr, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk1("abort_txd", bus_if.txd, 1'b1);
        chk1("abort_tbr", bus_if.tbr, 1'b1);
        chk1("abort_rda", bus_if.rda, 1'b0);
        repeat (50) step();
        chk1("abort_txd_hold", bus_if.txd, 1'b1);
        bus_read(2'b00, rd_val);
        chk8("abort_rxbuf", rd_val, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
